// File: rtl/mips_dmem_ctrl_if.sv
// rtl/mips_dmem_ctrl_if.sv - request/response bus between the MEM stage and the data-memory controller
interface mips_dmem_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mips_dmem_ctrl.sv
// rtl/mips_dmem_ctrl.sv - wait-stated byte/half/word/dword data memory; DMEM_STATS_EN adds access counters
module mips_dmem_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   mips_dmem_ctrl_if.slave bus,
   output logic            busy
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0]     stat_loads,
   output logic [15:0]     stat_stores,
   output logic [15:0]     stat_errs
`endif
);
   localparam int NB    = DATA_W / 8;
   localparam int OFFW  = $clog2(NB);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_t;
   state_t state, nstate;

   logic [3:0]        cnt;
   logic              r_we, r_sgn;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [DEPTH_LOG2-1:0] idx;
   logic [OFFW-1:0]       lane;
   logic [6:0]            nbits;
   logic [DATA_W-1:0]     mask, topb, rshift, rext, wshift;
   logic [NB-1:0]         be;
   logic [2:0]            amask;
   logic                  misal, size_bad, range_bad, err;

   assign idx  = r_addr[OFFW+DEPTH_LOG2-1:OFFW];
   assign lane = r_addr[OFFW-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE: if (bus.req_valid) nstate = (WAIT_CYCLES > 0) ? WAIT : EXEC;
         WAIT: if (cnt == 4'd0) nstate = EXEC;
         EXEC: nstate = RESP;
         RESP: if (bus.rsp_ready) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state == IDLE);
      bus.rsp_valid = (state == RESP);
      busy          = (state != IDLE);
   end

   // Lane extraction works on a right-shifted word; mask/topb cover the access width
   always_comb begin
      nbits     = 7'd8 << r_size;
      mask      = ~({DATA_W{1'b1}} << nbits);
      topb      = mask ^ (mask >> 1);
      rshift    = mem[idx] >> {lane, 3'b000};
      rext      = rshift & mask;
      if (r_sgn && |(rshift & topb)) rext = rext | ~mask;
      be        = ~({NB{1'b1}} << (4'd1 << r_size));
      be        = be << lane;
      wshift    = r_wdata << {lane, 3'b000};
      amask     = (3'd1 << r_size) - 3'd1;
      misal     = |(r_addr[2:0] & amask);
      size_bad  = (DATA_W == 32) && (r_size == 2'b11);
      range_bad = (r_addr >> (OFFW + DEPTH_LOG2)) != '0;
      err       = misal | size_bad | range_bad;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt           <= '0;
         r_we          <= 1'b0;
         r_sgn         <= 1'b0;
         r_size        <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         if (bus.req_valid && bus.req_ready) begin
            r_we    <= bus.req_we;
            r_sgn   <= bus.req_signed;
            r_size  <= bus.req_size;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            cnt     <= 4'(WAIT_CYCLES - 1);
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (state == EXEC) begin
            bus.rsp_rdata <= (r_we || err) ? '0 : rext;
            bus.rsp_err   <= err;
         end
      end
   end

   // Storage is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (state == EXEC && r_we && !err) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[idx][i*8 +: 8] <= wshift[i*8 +: 8];
         end
      end
   end

`ifdef DMEM_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_errs   <= '0;
      end else if (bus.rsp_valid && bus.rsp_ready) begin
         if (bus.rsp_err) begin
            if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
         end else if (r_we) begin
            if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
         end else begin
            if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
         end
      end
   end
`endif
endmodule

// File: doc/mips_dmem_ctrl.md
Name: mips_dmem_ctrl

Overview:
Parametrised data-memory block for the MIPS processor. It replaces the fixed-latency, word-only data memory. It accepts load/store requests over a valid/ready handshake and supports byte, half, word and (64-bit builds) dword accesses with sign/zero extension. It applies a configurable wait-state latency and flags misaligned or out-of-range accesses. It sits between the processor's MEM stage and the storage array.

Parameters:
- DATA_W, 32, data width in bits; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- DEPTH_LOG2, 10, log2 of the number of DATA_W-bit words.
- WAIT_CYCLES, 1, wait states between accept and response; 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- req_signed  in  1  sign-extend load data when 1.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  load data, right-aligned and extended; 0 for stores and errors.
- rsp_err  out  1  access was misaligned, out of range, or an illegal size.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Definitions: OFFW = log2(DATA_W/8). Word index = req_addr[OFFW+DEPTH_LOG2-1:OFFW]. Byte lane = req_addr[OFFW-1:0].
- Reset (rst low, asynchronous): go to IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0. Array contents are not reset.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch the request, then go to WAIT if WAIT_CYCLES>0, else EXEC.
  - WAIT: down-counter loaded with WAIT_CYCLES-1. Go to EXEC when the counter reaches 0.
  - EXEC: single cycle. Perform the checks and the array access, register the response, go to RESP.
  - RESP: rsp_valid=1. Hold rsp_rdata and rsp_err stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE; a new request may be accepted on the next cycle.
- Latency: accept edge to rsp_valid high = WAIT_CYCLES+1 cycles.
- Error conditions, any of which sets rsp_err=1 and suppresses the array write:
  - address not aligned to the access size;
  - size 11 when DATA_W=32;
  - address bits above OFFW+DEPTH_LOG2-1 nonzero.
- Stores: a byte-lane-masked write at the EXEC edge. Only the addressed lanes change.
- Loads: select the addressed lanes, then sign- or zero-extend to DATA_W.
- A store followed by a load to the same address returns the new data.
- rst asserted in WAIT: the request is dropped and the array is unchanged. rst asserted in RESP: the store has already been committed.
- req_valid while busy is ignored, with no side effects.

Optional Feature:
DMEM_STATS_EN
- Defined:
  - Adds 16-bit output ports stat_loads, stat_stores and stat_errs.
  - Each counter increments once per completed response handshake of that kind. Errored accesses count only in stat_errs.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Store word 0xDEADBEEF to addr 0x28, then load word from 0x28 (WAIT_CYCLES=1) -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid rises 2 cycles after each accept.
- After the previous test, store byte 0x7F to 0x29; load byte 0x2A signed -> 0xFFFFFFAD; load byte 0x29 unsigned -> 0x0000007F; load word 0x28 -> 0xDEAD7FEF.
- Load half from 0x2B, and separately store word to 0x2A -> rsp_err=1, rsp_rdata=0; a subsequent load word from 0x28 is unchanged.
- Load word from 0x00001000 with DEPTH_LOG2=10 -> rsp_err=1. Size 11 with DATA_W=32 -> rsp_err=1.
- Hold rsp_ready=0 for 5 cycles with req_valid high -> rsp_valid and rsp_rdata are stable, req_ready=0, and no second request is accepted. Raise rsp_ready -> back to IDLE the next cycle.
- Assert rst mid-WAIT on a store of 0x12345678 to 0x40 (WAIT_CYCLES=3) -> all outputs go to reset values immediately and a subsequent load from 0x40 returns the old data. With DMEM_STATS_EN defined, 2 loads + 1 store + 1 error give stat_loads=2, stat_stores=1, stat_errs=1.
